// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the instruction-fetch refill responder.
package mem_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

    localparam int WORD_OFS_W      = 2;
    localparam int RSP_LATENCY_MIN = 1;
    localparam int REQ_Q_DEPTH     = 2;

    // Latency counter width: ceil(log2(latency)), never narrower than 1 bit.
    function automatic int cnt_width(input int latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/req_fifo_2.sv
// Two-entry first-word-fall-through request queue; a pop frees the slot
// for a push on the same edge, so push into a full queue succeeds when popping.
module req_fifo_2
    import mem_rsp_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head_data,
    output logic        full,
    output logic        empty
);

    logic [31:0] slot_q [REQ_Q_DEPTH];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    assign full      = (count_q == 2'(REQ_Q_DEPTH));
    assign empty     = (count_q == 2'd0);
    assign head_data = slot_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q ^ do_pop;
        wr_ptr_d = wr_ptr_q ^ do_push;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: slot storage is deliberately not reset; the pointers and count qualify it.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_responder_i.sv
// Memory-side responder: fixed-latency word reads from a preloadable
// synchronous-read store, with a two-entry queue behind the FSM.
module mem_responder_i
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] r_addr,
    input  logic        request_valid,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data,
    output logic [31:0] r_data,
    output logic        rsp_valid,
    output logic        busy,
    output logic        overflow_err
);

    // Illegal latencies are clamped to the shortest supported one.
    localparam int LAT_EFF = (LATENCY < RSP_LATENCY_MIN) ? RSP_LATENCY_MIN : LATENCY;
    localparam int CNT_W   = cnt_width(LAT_EFF);
    localparam int WORDS   = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    rsp_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      r_data_q;

    logic        q_push, q_pop, q_full, q_empty;
    logic [31:0] q_head;
    logic        accepting, take, rd_fire;
    logic [31:0] take_addr;

    logic [31:0]           mem_q [WORDS];
    logic [DEPTH_LOG2-1:0] rd_idx, init_idx;
    logic                  unused_addr_bits;

    req_fifo_2 u_req_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (q_push),
        .push_data (r_addr),
        .pop       (q_pop),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q | (q_push && q_full && !q_pop);
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (take) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    addr_d  = take_addr;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accepting   = (state_q != WAIT);
        take        = accepting && (!q_empty || request_valid);
        take_addr   = q_empty ? r_addr : q_head;
        q_pop       = accepting && !q_empty;
        // A request bypasses the queue only when the FSM can take it and nothing is ahead of it.
        q_push      = request_valid && !(accepting && q_empty);
        rd_fire     = (state_q == WAIT) && (cnt_q == '0);
        rsp_valid_d = rd_fire;
        busy        = (state_q != IDLE) || !q_empty;
    end

    assign rd_idx   = addr_q[WORD_OFS_W +: DEPTH_LOG2];
    assign init_idx = init_addr[WORD_OFS_W +: DEPTH_LOG2];

    always_ff @(posedge CLK) begin
        if (init_we) begin
            mem_q[init_idx] <= init_data;
        end
    end

    // Same-edge preload of the word being read returns the pre-write contents.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_data_q <= '0;
        end else if (rd_fire) begin
            r_data_q <= mem_q[rd_idx];
        end
    end

    assign unused_addr_bits = ^{addr_q[31:WORD_OFS_W+DEPTH_LOG2], addr_q[WORD_OFS_W-1:0],
                                init_addr[31:WORD_OFS_W+DEPTH_LOG2], init_addr[WORD_OFS_W-1:0]};

    assign r_data       = r_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign overflow_err = ovf_q;

endmodule

// File: doc/mem_responder_i.md
# mem_responder_i

Memory-side responder for the instruction-fetch refill path. It accepts word-read requests (`r_addr`, `request_valid`) from the I-cache miss sender and returns `r_data` with a one-cycle `rsp_valid` strobe after a fixed, parameterised latency. The word store is a synchronous-read array that a loader port preloads. A two-entry request queue absorbs requests that arrive while a response is in flight.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words in the backing store.
- `LATENCY`, default 4: cycles from the request sampling edge to the `rsp_valid` setting edge. Legal values are 1 and above.

Ports:
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `r_addr`  in  32  byte address of the requested word.
- `request_valid`  in  1  request strobe, sampled every edge; there is no ready signal.
- `init_we`  in  1  preload write enable.
- `init_addr`  in  32  preload byte address.
- `init_data`  in  32  preload word.
- `r_data`  out  32  response word, registered.
- `rsp_valid`  out  1  one-cycle response strobe, registered.
- `busy`  out  1  asserted when `state != IDLE` or the queue is non-empty.
- `overflow_err`  out  1  sticky flag: a request was dropped.

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`.
  - `addr[1:0]` is ignored.
  - Upper bits are ignored, so the address space aliases and wraps.
- FSM has three states: `IDLE`, `WAIT`, `RESP`. It holds `cnt`, which is `ceil(log2(LATENCY))` bits wide and at least 1 bit.
- **IDLE**
  - If the queue is non-empty, pop the queue head.
  - Otherwise, if `request_valid` is high, take `r_addr` directly (bypass).
  - When a request is taken, latch its address, load `cnt = LATENCY-1` and go to `WAIT`.
- **WAIT**
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, register `r_data <= mem[idx]`, set `rsp_valid <= 1` and go to `RESP`.
- **RESP**
  - Clear `rsp_valid`.
  - Take the next request with the same priority as IDLE (queue head first, then bypass). If one is taken, load `cnt` and go to `WAIT`. Otherwise go to `IDLE`.
- **Request queue**
  - A request sampled while it is not being consumed that edge is pushed. "Not consumed" means the state is `WAIT`, or the state is `IDLE`/`RESP` with a non-empty queue.
  - If the queue is full at that edge, the request is dropped and `overflow_err` is set. `overflow_err` clears only on reset.
  - A pop and a push on the same edge are legal when the queue is full: the push succeeds.
- **Preload**
  - `init_we` writes `mem[init_addr index] <= init_data` on the edge.
  - Reading the same index on the same edge returns the old word (read-before-write).
  - Preload is allowed in any state.
- `r_data` holds its last value between responses.

## Timing
- **Reset values:** `rsp_valid = 0`, `r_data = 0`, `busy = 0`, `overflow_err = 0`, state `IDLE`, `cnt = 0`, queue empty. Memory contents are not reset and survive reset.
- **Unloaded latency:** a request sampled at edge E0 in `IDLE` with an empty queue sets `rsp_valid` and `r_data` at edge E0+LATENCY. Both are cleared or held at E0+LATENCY+1.
- **Queued request:** popped at the edge that leaves `RESP`, at edge Ep. Its response is set at Ep+LATENCY. Steady-state throughput is one response per LATENCY+1 cycles.
- **Request sampled in `RESP` with an empty queue:** bypassed at that edge; it is not queued.
- **Reset mid-operation:** asynchronous assertion immediately drops `rsp_valid` and discards in-flight and queued requests. No response is issued after deassertion.

## Structure
- Package `mem_rsp_pkg` holds:
  - the `rsp_state_t` enum (`IDLE`, `WAIT`, `RESP`);
  - `WORD_OFS_W = 2`;
  - `RSP_LATENCY_MIN = 1`;
  - `REQ_Q_DEPTH = 2`.
- Sub-module `req_fifo_2`: two-entry, 32-bit FIFO with push, pop, full and empty. It is first-word-fall-through, shares `CLK` and `RESET`, and has an asynchronous active-low clear.
- The top level holds the FSM, counter, storage array and output registers.

## Test plan
All scenarios use `LATENCY=4` and `DEPTH_LOG2=10`.
1. **Reset:** assert `RESET=0` with random inputs -> all outputs 0. After release, `busy=0`.
2. **Single read:** preload `0x00000040 <- 0xDEADBEEF`, then request `0x40` at E0 -> `rsp_valid=1` only in the cycle after E4, with `r_data=0xDEADBEEF`.
3. **Back-to-back:** requests for `0x0`, `0x4`, `0x8` at E0, E1, E2 -> responses set at E4, E9, E14 in order, and `overflow_err=0`.
4. **Overflow:** requests at E0, E1, E2, E3 -> the E3 request is dropped, `overflow_err=1` after E3, and exactly three responses occur.
5. **Aliasing and misalignment:**
   - Requests `0x00001040` and `0x00000042` -> both return `0xDEADBEEF`.
   - Preload `0x40` on the same edge as its read -> the old word is returned.
6. **Reset mid-operation:** pulse `RESET` low two cycles after a request -> no `rsp_valid`, `busy=0`. A later request to `0x40` still returns `0xDEADBEEF`.
